program_dumper: RTL and testbench
=================================

# program_dumper

Sequential reader for the MCPU instruction RAM: on `start` it walks an address window, reads each stored word, splits it into opcode and three operand fields, and presents them one at a time on a valid/ready stream. It is the hardware read-back counterpart of the bench assembler that fills the RAM. It sits beside `MCPU` on a second RAM read port and lets a bench or debug host dump and check a loaded program.

## Interface
- `WORD_SIZE`, 16, RAM word / instruction width
- `OPCODE_SIZE`, 4, opcode field width (bits `[WORD_SIZE-1 -: OPCODE_SIZE]`)
- `OPERAND_SIZE`, 4, width of each of the three operand fields
- `ADDR_SIZE`, 8, RAM address width; RAM_SIZE = 2**ADDR_SIZE
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a dump; sampled only in IDLE
- `first_addr`  in  ADDR_SIZE  first address, sampled with `start`
- `last_addr`  in  ADDR_SIZE  final address inclusive, sampled with `start`
- `mem_rd`  out  1  RAM read strobe
- `mem_addr`  out  ADDR_SIZE  RAM read address
- `mem_data`  in  WORD_SIZE  RAM read data, valid the cycle after `mem_rd`
- `out_valid`  out  1  output fields valid
- `out_ready`  in  1  consumer accepts the current word
- `out_addr`  out  ADDR_SIZE  address of the presented word
- `out_word`  out  WORD_SIZE  raw word
- `out_opcode`  out  OPCODE_SIZE  bits `[15:12]`
- `out_op1`, `out_op2`, `out_op3`  out  OPERAND_SIZE each  bits `[11:8]`, `[7:4]`, `[3:0]`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last word is accepted
- `nonzero_count`  out  ADDR_SIZE+1  number of accepted words that were nonzero in the current or most recent dump

## Operation
- States: IDLE, ISSUE, CAPTURE, OUT, DONE.
- IDLE: `start`=1 loads `cur`←`first_addr` and `last`←`last_addr`, clears `nonzero_count`, and goes to ISSUE. Otherwise it stays in IDLE.
- ISSUE: `mem_rd`=1 and `mem_addr`=`cur`, then go to CAPTURE. `mem_rd` is 0 in every other state.
- CAPTURE: register `mem_data` into `out_word` and the split fields, and `cur` into `out_addr`, then go to OUT.
- OUT: `out_valid`=1, and all out_* fields stay stable until the handshake (`out_valid & out_ready` at a rising edge).
  - On handshake, `nonzero_count` increments if `out_word` != 0.
  - If `cur`==`last`, go to DONE; otherwise `cur`←`cur`+1 modulo RAM_SIZE and go to ISSUE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Window wrap-around: if `last_addr` < `first_addr`, the walk passes through RAM_SIZE-1 to 0 and stops at `last`.
  - `first_addr`==`last_addr` dumps exactly one word.
  - first=0, last=RAM_SIZE-1 dumps all RAM_SIZE words; `nonzero_count` max is RAM_SIZE, hence ADDR_SIZE+1 bits.
- `start` while busy is ignored; the window inputs are not re-sampled.
- `out_ready` outside OUT has no effect.

## Timing
- Reset values: state IDLE; `mem_rd`, `out_valid`, `busy`, `done` = 0; `mem_addr`, `out_addr`, `out_word`, fields = 0; `nonzero_count` = 0.
- Reset asserted mid-dump: all of the above at the next edge. No partial `done` pulse and no further `mem_rd`.
- `start` sampled at edge E0:
  - ISSUE in cycle after E0
  - CAPTURE next cycle (`mem_data` valid)
  - `out_valid` high in the cycle after that
- Throughput: minimum 3 cycles per word with `out_ready` held high; each extra cycle of low `out_ready` adds one.
- Latency `start` to first `out_valid`: 3 cycles.
- `done` rises in the cycle after the last handshake; `busy` falls in the cycle after `done`.
- `nonzero_count` is valid once `done` pulses and holds until the next accepted `start`.

## Test plan
- Load mem[1]=16'h7E02, mem[2]=16'h7F03, mem[3]=16'hA51E, mem[4]=16'hB61F; first=1, last=4, `out_ready`=1 -> 4 words at addrs 1..4 spaced 3 cycles apart. Word at addr 3 gives opcode=A, op1=5, op2=1, op3=E. Then `done` pulses once and `nonzero_count`=4.
- Same load, window 0..5 -> 6 words; addrs 0 and 5 read 0; `nonzero_count`=4.
- Wrap: first=254, last=1 -> addr order 254, 255, 0, 1, then `done`.
- Backpressure: hold `out_ready`=0 for 5 cycles on the word at addr 2 -> `out_valid` and fields stay stable and no `mem_rd` is issued; the word is accepted on the first ready cycle and addr 3 follows 3 cycles later.
- `start` pulsed during a dump of 1..4 -> ignored, exactly 4 words. `first_addr`==`last_addr`=3 -> single word 16'hA51E, `done`.
- Assert `reset` on the cycle the addr-2 word is valid -> next cycle `out_valid`=`busy`=`mem_rd`=0 and `nonzero_count`=0; no `done`. A new `start` then dumps from its `first_addr`.

Source files
------------

// File: rtl/program_dumper.sv
// ---------------------------------------------------------------------------
// program_dumper
//
// Walks an inclusive address window of the MCPU instruction RAM through a
// second read port. It reads each word, splits it into opcode and three
// operand fields, and presents the words one at a time on a valid/ready
// output stream.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   start                    begin a dump (sampled only in IDLE)
//   first_addr, last_addr    inclusive window, sampled with start; wraps past
//                            RAM_SIZE-1 when last_addr < first_addr
//   mem_rd, mem_addr         RAM read strobe and address
//   mem_data                 RAM read data, valid the cycle after mem_rd
//   out_valid, out_ready     output handshake
//   out_addr, out_word       address and raw word currently presented
//   out_opcode, out_op1..3   split fields of out_word
//   busy                     high in every state except IDLE
//   done                     one-cycle pulse after the last word is accepted
//   nonzero_count            count of accepted nonzero words in this dump
//   dbg_state                current FSM state, for debug and checkers
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high. While out_valid is high, all out_* fields hold steady until
// that transfer. out_ready has no effect outside the OUT state.
// ---------------------------------------------------------------------------
module program_dumper #(
    parameter int WORD_SIZE    = 16,
    parameter int OPCODE_SIZE  = 4,
    parameter int OPERAND_SIZE = 4,
    parameter int ADDR_SIZE    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_SIZE-1:0]    first_addr,
    input  logic [ADDR_SIZE-1:0]    last_addr,
    output logic                    mem_rd,
    output logic [ADDR_SIZE-1:0]    mem_addr,
    input  logic [WORD_SIZE-1:0]    mem_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_SIZE-1:0]    out_addr,
    output logic [WORD_SIZE-1:0]    out_word,
    output logic [OPCODE_SIZE-1:0]  out_opcode,
    output logic [OPERAND_SIZE-1:0] out_op1,
    output logic [OPERAND_SIZE-1:0] out_op2,
    output logic [OPERAND_SIZE-1:0] out_op3,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_SIZE:0]      nonzero_count,
    output logic [2:0]              dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_OUT     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0]   CNT_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] cur_q, cur_d;
    logic [ADDR_SIZE-1:0] last_q, last_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic [ADDR_SIZE:0]   nz_q, nz_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        addr_d  = addr_q;
        word_d  = word_q;
        nz_d    = nz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    nz_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                word_d  = mem_data;
                addr_d  = cur_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (word_q != '0) begin
                        nz_d = nz_q + CNT_ONE;
                    end
                    // Equality stop test plus natural overflow of cur
                    // handles windows that wrap through RAM_SIZE-1 to 0.
                    if (cur_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + ADDR_ONE;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            nz_q    <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            nz_q    <= nz_d;
        end
    end

    // All control outputs decode directly from the registered state, so a
    // reset clears them at the same edge with no partial pulses.
    assign mem_rd        = (state_q == S_ISSUE);
    assign mem_addr      = cur_q;
    assign out_valid     = (state_q == S_OUT);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign out_addr      = addr_q;
    assign out_word      = word_q;
    assign out_opcode    = word_q[WORD_SIZE-1 -: OPCODE_SIZE];
    assign out_op1       = word_q[3*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign out_op2       = word_q[2*OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign out_op3       = word_q[OPERAND_SIZE-1 -: OPERAND_SIZE];
    assign nonzero_count = nz_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_program_dumper.sv
module tb_program_dumper;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  first_addr = '0;
  logic [7:0]  last_addr = '0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_addr;
  logic [15:0] out_word;
  logic [3:0]  out_opcode, out_op1, out_op2, out_op3;
  logic        busy, done;
  logic [8:0]  nonzero_count;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  program_dumper dut (
    .clk(clk), .reset(reset), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_word(out_word), .out_opcode(out_opcode),
    .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3),
    .busy(busy), .done(done), .nonzero_count(nonzero_count),
    .dbg_state(dbg_state)
  );

  // RAM model: registered read, data valid the cycle after mem_rd
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (mem_rd) mem_data <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  // entry = {first_of_dump, expected_gap_in_edges[7:0], addr[7:0], word[15:0]}
  localparam int W = 33;
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int edge_n = 0;
  int start_edge = 0;
  int last_hs = 0;
  int done_seen = 0;

  typedef struct {
    logic [7:0] f;
    logic [7:0] l;
    logic [8:0] nz;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // One clock cycle: observe outputs at negedge, then return at posedge+1.
  task automatic step();
    logic [W-1:0] e;
    int hs;
    int base;
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      hs = edge_n + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {8'h0, out_addr, out_word}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        base = e[32] ? start_edge : last_hs;
        chk("addr_word", {8'h0, out_addr, out_word}, {8'h0, e[23:0]});
        chk("fields", {16'h0, out_opcode, out_op1, out_op2, out_op3},
            {16'h0, e[15:12], e[11:8], e[7:4], e[3:0]});
        chk("gap", hs - base, {24'h0, e[31:24]});
      end
      last_hs = hs;
    end
    if (done) done_seen++;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Runs one dump. stall_addr / reset_addr < 0 disables that corner case.
  task automatic run_dump(input logic [7:0] f, input logic [7:0] l,
                          input logic [8:0] exp_nz, input int stall_addr,
                          input bit pulse, input int reset_addr);
    logic [7:0] a;
    int n_pushed;
    int it;
    int d0;
    bit stalled;
    logic [7:0] gap;
    a = f;
    n_pushed = 0;
    stalled = 0;
    for (int k = 0; k < 256; k++) begin
      gap = (int'(a) == stall_addr) ? 8'd8 : 8'd3;
      exp_q.push_back({(k == 0), gap, a, ram[a]});
      n_pushed++;
      if (a == l) break;
      a = a + 8'd1;
    end
    first_addr = f;
    last_addr = l;
    start = 1'b1;
    start_edge = edge_n + 1;
    step();
    start = 1'b0;
    chk("issue_rd", {31'h0, mem_rd}, 32'h1);
    chk("issue_addr", {24'h0, mem_addr}, {24'h0, f});
    d0 = done_seen;
    it = 0;
    while (it < 3000 && !done) begin
      if (reset_addr >= 0 && out_valid && int'(out_addr) == reset_addr) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_nz", {23'h0, nonzero_count}, 32'h0);
        chk("rst_out_word", {16'h0, out_word}, 32'h0);
        chk("rst_leftover", exp_q.size(), n_pushed - (reset_addr - int'(f)));
        exp_q.delete();
        for (int j = 0; j < 4; j++) begin
          step();
          chk("rst_no_done", done_seen, d0);
          chk("rst_idle_rd", {30'h0, mem_rd, busy}, 32'h0);
        end
        return;
      end
      if (stall_addr >= 0 && !stalled && out_valid && int'(out_addr) == stall_addr) begin
        stalled = 1;
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          step();
          chk("stall_valid", {31'h0, out_valid}, 32'h1);
          chk("stall_word", {8'h0, out_addr, out_word},
              {8'h0, stall_addr[7:0], ram[stall_addr[7:0]]});
          chk("stall_no_rd", {31'h0, mem_rd}, 32'h0);
        end
        out_ready = 1'b1;
      end
      if (pulse && it == 5) begin
        start = 1'b1;
        first_addr = 8'h40;
        last_addr = 8'h41;
      end
      if (pulse && it == 6) start = 1'b0;
      step();
      it++;
    end
    start = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
      exp_q.delete();
      return;
    end
    chk("done_nz", {23'h0, nonzero_count}, {23'h0, exp_nz});
    chk("done_busy", {31'h0, busy}, 32'h1);
    chk("queue_empty", exp_q.size(), 0);
    step();
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("busy_fall", {31'h0, busy}, 32'h0);
    chk("done_pulses", done_seen - d0, 1);
    chk("nz_hold", {23'h0, nonzero_count}, {23'h0, exp_nz});
  endtask

  initial begin
    tbl[0] = '{f: 8'd1,   l: 8'd4,   nz: 9'd4};
    tbl[1] = '{f: 8'd0,   l: 8'd5,   nz: 9'd4};
    tbl[2] = '{f: 8'd254, l: 8'd1,   nz: 9'd2};
    tbl[3] = '{f: 8'd3,   l: 8'd3,   nz: 9'd1};
    tbl[4] = '{f: 8'd0,   l: 8'd255, nz: 9'd5};

    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    ram[1] = 16'h7E02;
    ram[2] = 16'h7F03;
    ram[3] = 16'hA51E;
    ram[4] = 16'hB61F;
    ram[254] = 16'h1234;

    // reset state
    repeat (3) step();
    chk("rst_ctrl", {28'h0, mem_rd, out_valid, busy, done}, 32'h0);
    chk("rst_addrs", {16'h0, mem_addr, out_addr}, 32'h0);
    chk("rst_word", {16'h0, out_word}, 32'h0);
    chk("rst_fields", {16'h0, out_opcode, out_op1, out_op2, out_op3}, 32'h0);
    chk("rst_count", {23'h0, nonzero_count}, 32'h0);
    chk("rst_state", {29'h0, dbg_state}, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_no_start", {31'h0, busy}, 32'h0);

    // table-driven windows
    for (int i = 0; i < 5; i++) begin
      run_dump(tbl[i].f, tbl[i].l, tbl[i].nz, -1, 0, -1);
      step();
    end

    // backpressure on addr 2
    run_dump(8'd1, 8'd4, 9'd4, 2, 0, -1);
    step();
    // start pulsed mid-dump is ignored
    run_dump(8'd1, 8'd4, 9'd4, -1, 1, -1);
    step();
    // reset while addr 2 is presented, then a fresh dump
    run_dump(8'd1, 8'd4, 9'd0, -1, 0, 2);
    run_dump(8'd3, 8'd4, 9'd2, -1, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
